// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared opcode, funct, ALU-op and branch encodings for the ID stage
package pipe_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2a;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_SLT  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;

    localparam logic [1:0] BR_NONE  = 2'b00;
    localparam logic [1:0] BR_BEQ   = 2'b01;
    localparam logic [1:0] BR_BNE   = 2'b10;

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational instruction decode into ID/EX control, immediate and register usage
// Ports: instr in; rs_addr/rt_addr/rw/shamt register fields; imm; alu_op; branch;
//        reg_write/mem_read/mem_write/alu_src control; use_rs/use_rt; is_jump; illegal.
module instr_decoder (
    input  logic [31:0] instr,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    output logic [4:0]  rw,
    output logic [4:0]  shamt,
    output logic [31:0] imm,
    output logic [3:0]  alu_op,
    output logic [1:0]  branch,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        alu_src,
    output logic        use_rs,
    output logic        use_rt,
    output logic        is_jump,
    output logic        illegal
);
    import pipe_pkg::*;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       wr;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign shamt  = instr[10:6];

    always_comb begin
        rs_addr   = instr[25:21];
        rt_addr   = instr[20:16];
        rw        = 5'd0;
        imm       = sign_ext16(instr[15:0]);
        alu_op    = ALU_ADD;
        branch    = BR_NONE;
        wr        = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        alu_src   = 1'b0;
        use_rs    = 1'b0;
        use_rt    = 1'b0;
        is_jump   = 1'b0;
        illegal   = 1'b0;
        unique case (opcode)
            OP_RTYPE: begin
                rw     = instr[15:11];
                wr     = 1'b1;
                use_rs = 1'b1;
                use_rt = 1'b1;
                unique case (funct)
                    FN_ADD: alu_op = ALU_ADD;
                    FN_SUB: alu_op = ALU_SUB;
                    FN_AND: alu_op = ALU_AND;
                    FN_OR:  alu_op = ALU_OR;
                    FN_SLT: alu_op = ALU_SLT;
                    // Shifts take their amount from shamt, so rs is not a real source.
                    FN_SLL: begin alu_op = ALU_SLL; use_rs = 1'b0; end
                    FN_SRL: begin alu_op = ALU_SRL; use_rs = 1'b0; end
                    default: begin
                        illegal = 1'b1;
                        wr      = 1'b0;
                        use_rs  = 1'b0;
                        use_rt  = 1'b0;
                    end
                endcase
            end
            OP_ADDI: begin
                rw = instr[20:16]; wr = 1'b1; use_rs = 1'b1; alu_src = 1'b1;
            end
            OP_ANDI: begin
                rw = instr[20:16]; wr = 1'b1; use_rs = 1'b1; alu_src = 1'b1;
                alu_op = ALU_AND; imm = {16'h0, instr[15:0]};
            end
            OP_ORI: begin
                rw = instr[20:16]; wr = 1'b1; use_rs = 1'b1; alu_src = 1'b1;
                alu_op = ALU_OR; imm = {16'h0, instr[15:0]};
            end
            OP_LUI: begin
                // Executed as 0 + (imm << 16): force the rs read to $0.
                rs_addr = 5'd0;
                rw = instr[20:16]; wr = 1'b1; alu_src = 1'b1;
                imm = {instr[15:0], 16'h0};
            end
            OP_LW: begin
                rw = instr[20:16]; wr = 1'b1; use_rs = 1'b1; alu_src = 1'b1;
                mem_read = 1'b1;
            end
            OP_SW: begin
                use_rs = 1'b1; use_rt = 1'b1; alu_src = 1'b1; mem_write = 1'b1;
            end
            OP_BEQ: begin
                use_rs = 1'b1; use_rt = 1'b1; alu_op = ALU_SUB; branch = BR_BEQ;
            end
            OP_BNE: begin
                use_rs = 1'b1; use_rt = 1'b1; alu_op = ALU_SUB; branch = BR_BNE;
            end
            OP_J:    is_jump = 1'b1;
            default: illegal = 1'b1;
        endcase
        // A write to $0 is architecturally discarded; never signal it.
        reg_write = wr & (rw != 5'd0);
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - ID stage: decode, register read, load-use stall, J redirect, ID/EX register
// Ports: clock/clear; IF/ID inputs if_valid/if_instr/if_pc4; mem_stall, ex_flush;
//        RA/RB read addresses and read_data1/read_data2; stall_out, jump_valid/jump_target;
//        illegal_instr pulse; ex_* ID/EX pipeline register outputs.
module decode_stage #(
    parameter logic [31:0] RESET_PC4 = 32'h00000004
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc4,
    input  logic        mem_stall,
    input  logic        ex_flush,
    output logic [4:0]  RA,
    output logic [4:0]  RB,
    input  logic [31:0] read_data1,
    input  logic [31:0] read_data2,
    output logic        stall_out,
    output logic        jump_valid,
    output logic [31:0] jump_target,
    output logic        illegal_instr,
    output logic        ex_valid,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_alu_src,
    output logic [1:0]  ex_branch,
    output logic [3:0]  ex_alu_op,
    output logic [31:0] ex_rs_val,
    output logic [31:0] ex_rt_val,
    output logic [31:0] ex_imm,
    output logic [31:0] ex_pc4,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_rw,
    output logic [4:0]  ex_shamt
);
    import pipe_pkg::*;

    logic [4:0]  d_rs;
    logic [4:0]  d_rt;
    logic [4:0]  d_rw;
    logic [4:0]  d_shamt;
    logic [31:0] d_imm;
    logic [3:0]  d_alu_op;
    logic [1:0]  d_branch;
    logic        d_reg_write;
    logic        d_mem_read;
    logic        d_mem_write;
    logic        d_alu_src;
    logic        d_use_rs;
    logic        d_use_rt;
    logic        d_is_jump;
    logic        d_illegal;
    logic        hz;
    logic        issue;

    instr_decoder u_dec (
        .instr     (if_instr),
        .rs_addr   (d_rs),
        .rt_addr   (d_rt),
        .rw        (d_rw),
        .shamt     (d_shamt),
        .imm       (d_imm),
        .alu_op    (d_alu_op),
        .branch    (d_branch),
        .reg_write (d_reg_write),
        .mem_read  (d_mem_read),
        .mem_write (d_mem_write),
        .alu_src   (d_alu_src),
        .use_rs    (d_use_rs),
        .use_rt    (d_use_rt),
        .is_jump   (d_is_jump),
        .illegal   (d_illegal)
    );

    assign RA = d_rs;
    assign RB = d_rt;

    // Load in EX whose result is needed now; the bubble clears ex_mem_read so this lasts one cycle.
    assign hz = if_valid & ex_valid & ex_mem_read & (ex_rw != 5'd0) &
                ((d_use_rs & (d_rs == ex_rw)) | (d_use_rt & (d_rt == ex_rw)));

    assign stall_out   = hz & ~mem_stall & ~ex_flush;
    assign jump_valid  = if_valid & d_is_jump & ~mem_stall & ~ex_flush;
    assign jump_target = {if_pc4[31:28], if_instr[25:0], 2'b00};

    assign issue = if_valid & ~ex_flush & ~hz & ~d_illegal & ~d_is_jump;

    always_ff @(posedge clock) begin
        if (clear) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_branch     <= BR_NONE;
            ex_alu_op     <= ALU_ADD;
            ex_rs_val     <= 32'h0;
            ex_rt_val     <= 32'h0;
            ex_imm        <= 32'h0;
            ex_pc4        <= RESET_PC4;
            ex_rs         <= 5'd0;
            ex_rt         <= 5'd0;
            ex_rw         <= 5'd0;
            ex_shamt      <= 5'd0;
            illegal_instr <= 1'b0;
        end else if (mem_stall) begin
            illegal_instr <= 1'b0;
        end else begin
            // Data fields always load; only the control bits distinguish a bubble.
            ex_valid      <= issue;
            ex_reg_write  <= issue & d_reg_write;
            ex_mem_read   <= issue & d_mem_read;
            ex_mem_write  <= issue & d_mem_write;
            ex_branch     <= issue ? d_branch : BR_NONE;
            ex_alu_src    <= d_alu_src;
            ex_alu_op     <= d_alu_op;
            ex_rs_val     <= read_data1;
            ex_rt_val     <= read_data2;
            ex_imm        <= d_imm;
            ex_pc4        <= if_pc4;
            ex_rs         <= d_rs;
            ex_rt         <= d_rt;
            ex_rw         <= d_rw;
            ex_shamt      <= d_shamt;
            illegal_instr <= if_valid & d_illegal & ~ex_flush;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed table-driven self-checking bench for decode_stage
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        clear;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc4;
    logic        mem_stall;
    logic        ex_flush;
    logic [4:0]  RA;
    logic [4:0]  RB;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic        stall_out;
    logic        jump_valid;
    logic [31:0] jump_target;
    logic        illegal_instr;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src;
    logic [1:0]  ex_branch;
    logic [3:0]  ex_alu_op;
    logic [31:0] ex_rs_val, ex_rt_val, ex_imm, ex_pc4;
    logic [4:0]  ex_rs, ex_rt, ex_rw, ex_shamt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] regs [32];

    always #5 clock = ~clock;

    // Register file model: $0 reads as zero.
    always_comb begin
        read_data1 = (RA == 5'd0) ? 32'h0 : regs[RA];
        read_data2 = (RB == 5'd0) ? 32'h0 : regs[RB];
    end

    decode_stage #(.RESET_PC4(32'h00000004)) dut (
        .clock(clock), .clear(clear), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc4(if_pc4), .mem_stall(mem_stall), .ex_flush(ex_flush),
        .RA(RA), .RB(RB), .read_data1(read_data1), .read_data2(read_data2),
        .stall_out(stall_out), .jump_valid(jump_valid), .jump_target(jump_target),
        .illegal_instr(illegal_instr), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
        .ex_branch(ex_branch), .ex_alu_op(ex_alu_op), .ex_rs_val(ex_rs_val),
        .ex_rt_val(ex_rt_val), .ex_imm(ex_imm), .ex_pc4(ex_pc4), .ex_rs(ex_rs),
        .ex_rt(ex_rt), .ex_rw(ex_rw), .ex_shamt(ex_shamt)
    );

    typedef struct {
        logic        vld;
        logic [31:0] instr;
        logic [4:0]  ra, rb;
        logic        jv;
        logic        ev, rwe, mr, mw, src;
        logic [1:0]  br;
        logic [3:0]  op;
        logic [31:0] imm;
        logic [4:0]  rw;
        logic [31:0] rsv, rtv;
        logic [4:0]  sh;
        logic        ill;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_idle();
        if_valid = 1'b0; if_instr = 32'h0; if_pc4 = 32'h0;
        mem_stall = 1'b0; ex_flush = 1'b0;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc4);
        if_valid = 1'b1; if_instr = instr; if_pc4 = pc4;
        #1;
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int sh, input int fn);
        logic [31:0] a, b, c, d, e;
        a = rs; b = rt; c = rd; d = sh; e = fn;
        return {6'h00, a[4:0], b[4:0], c[4:0], d[4:0], e[5:0]};
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs, input int rt, input logic [15:0] imm);
        logic [31:0] a, b, c;
        a = op; b = rs; c = rt;
        return {a[5:0], b[4:0], c[4:0], imm};
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = i;

        //          vld  instr                          ra  rb  jv ev rwe mr mw src br    op  imm            rw   rsv    rtv    sh ill
        vecs[0]  = '{1, 32'h00221820,                    1,  2, 0, 1, 1, 0, 0, 0, 2'd0, 4'd0, 32'h00001820,  3, 32'd1, 32'd2, 0, 0};
        vecs[1]  = '{1, rtype(4, 5, 6, 0, 'h22),         4,  5, 0, 1, 1, 0, 0, 0, 2'd0, 4'd1, 32'h00003022,  6, 32'd4, 32'd5, 0, 0};
        vecs[2]  = '{1, rtype(2, 3, 8, 0, 'h24),         2,  3, 0, 1, 1, 0, 0, 0, 2'd0, 4'd2, 32'h00004024,  8, 32'd2, 32'd3, 0, 0};
        vecs[3]  = '{1, rtype(5, 6, 9, 0, 'h25),         5,  6, 0, 1, 1, 0, 0, 0, 2'd0, 4'd3, 32'h00004825,  9, 32'd5, 32'd6, 0, 0};
        vecs[4]  = '{1, rtype(1, 2, 10, 0, 'h2a),        1,  2, 0, 1, 1, 0, 0, 0, 2'd0, 4'd4, 32'h0000502a, 10, 32'd1, 32'd2, 0, 0};
        vecs[5]  = '{1, rtype(0, 2, 11, 4, 'h00),        0,  2, 0, 1, 1, 0, 0, 0, 2'd0, 4'd5, 32'h00005900, 11, 32'd0, 32'd2, 4, 0};
        vecs[6]  = '{1, rtype(0, 3, 12, 31, 'h02),       0,  3, 0, 1, 1, 0, 0, 0, 2'd0, 4'd6, 32'h000067c2, 12, 32'd0, 32'd3, 31, 0};
        vecs[7]  = '{1, itype('h08, 1, 12, 16'hfffd),    1, 12, 0, 1, 1, 0, 0, 1, 2'd0, 4'd0, 32'hfffffffd, 12, 32'd1, 32'd12, 0, 0};
        vecs[8]  = '{1, itype('h0c, 1, 13, 16'h8001),    1, 13, 0, 1, 1, 0, 0, 1, 2'd0, 4'd2, 32'h00008001, 13, 32'd1, 32'd13, 0, 0};
        vecs[9]  = '{1, itype('h23, 10, 4, 16'h0008),   10,  4, 0, 1, 1, 1, 0, 1, 2'd0, 4'd0, 32'h00000008,  4, 32'd10, 32'd4, 0, 0};
        vecs[10] = '{1, itype('h2b, 10, 4, 16'hfffc),   10,  4, 0, 1, 0, 0, 1, 1, 2'd0, 4'd0, 32'hfffffffc,  0, 32'd10, 32'd4, 31, 0};
        vecs[11] = '{1, itype('h04, 1, 2, 16'hffff),     1,  2, 0, 1, 0, 0, 0, 0, 2'd1, 4'd1, 32'hffffffff,  0, 32'd1, 32'd2, 31, 0};
        vecs[12] = '{1, itype('h05, 3, 4, 16'h0010),     3,  4, 0, 1, 0, 0, 0, 0, 2'd2, 4'd1, 32'h00000010,  0, 32'd3, 32'd4, 0, 0};
        vecs[13] = '{1, itype('h0f, 0, 7, 16'h1234),     0,  7, 0, 1, 1, 0, 0, 1, 2'd0, 4'd0, 32'h12340000,  7, 32'd0, 32'd7, 8, 0};
        vecs[14] = '{1, itype('h0d, 7, 7, 16'hffff),     7,  7, 0, 1, 1, 0, 0, 1, 2'd0, 4'd3, 32'h0000ffff,  7, 32'd7, 32'd7, 31, 0};
        vecs[15] = '{1, itype('h08, 1, 0, 16'h0005),     1,  0, 0, 1, 0, 0, 0, 1, 2'd0, 4'd0, 32'h00000005,  0, 32'd1, 32'd0, 0, 0};
        vecs[16] = '{1, rtype(1, 2, 3, 0, 'h3f),         1,  2, 0, 0, 0, 0, 0, 0, 2'd0, 4'd0, 32'h0,         0, 32'd0, 32'd0, 0, 1};
        vecs[17] = '{1, itype('h3f, 1, 2, 16'h0000),     1,  2, 0, 0, 0, 0, 0, 0, 2'd0, 4'd0, 32'h0,         0, 32'd0, 32'd0, 0, 1};
        vecs[18] = '{1, 32'h08040000,                    0,  4, 1, 0, 0, 0, 0, 0, 2'd0, 4'd0, 32'h0,         0, 32'd0, 32'd0, 0, 0};
        vecs[19] = '{0, itype('h3f, 1, 2, 16'h0000),     1,  2, 0, 0, 0, 0, 0, 0, 2'd0, 4'd0, 32'h0,         0, 32'd0, 32'd0, 0, 0};

        // Reset: two cycles of clear with an idle IF/ID.
        set_idle();
        clear = 1'b1;
        tick();
        tick();
        check("rst_ex_valid", {31'h0, ex_valid}, 32'h0);
        check("rst_ex_pc4", ex_pc4, 32'h4);
        check("rst_stall", {31'h0, stall_out}, 32'h0);
        check("rst_jump", {31'h0, jump_valid}, 32'h0);
        check("rst_ctrl", {26'h0, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_branch}, 32'h0);
        check("rst_alu_op", {28'h0, ex_alu_op}, 32'h0);
        check("rst_rw", {27'h0, ex_rw}, 32'h0);
        check("rst_illegal", {31'h0, illegal_instr}, 32'h0);
        clear = 1'b0;

        for (int i = 0; i < 20; i++) begin
            logic [31:0] pc4;
            pc4 = 32'h00001000 + 32'(i) * 4;
            set_idle();
            tick();
            check($sformatf("v%0d_pre_illegal", i), {31'h0, illegal_instr}, 32'h0);
            if_valid = vecs[i].vld; if_instr = vecs[i].instr; if_pc4 = pc4;
            #1;
            check($sformatf("v%0d_RA", i), {27'h0, RA}, {27'h0, vecs[i].ra});
            check($sformatf("v%0d_RB", i), {27'h0, RB}, {27'h0, vecs[i].rb});
            check($sformatf("v%0d_jump_valid", i), {31'h0, jump_valid}, {31'h0, vecs[i].jv});
            check($sformatf("v%0d_stall", i), {31'h0, stall_out}, 32'h0);
            tick();
            check($sformatf("v%0d_ex_valid", i), {31'h0, ex_valid}, {31'h0, vecs[i].ev});
            check($sformatf("v%0d_ctrl", i), {27'h0, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch},
                  {27'h0, vecs[i].rwe, vecs[i].mr, vecs[i].mw, vecs[i].br});
            check($sformatf("v%0d_illegal", i), {31'h0, illegal_instr}, {31'h0, vecs[i].ill});
            if (vecs[i].ev) begin
                check($sformatf("v%0d_alu_op", i), {28'h0, ex_alu_op}, {28'h0, vecs[i].op});
                check($sformatf("v%0d_alu_src", i), {31'h0, ex_alu_src}, {31'h0, vecs[i].src});
                check($sformatf("v%0d_imm", i), ex_imm, vecs[i].imm);
                check($sformatf("v%0d_rw", i), {27'h0, ex_rw}, {27'h0, vecs[i].rw});
                check($sformatf("v%0d_rs_val", i), ex_rs_val, vecs[i].rsv);
                check($sformatf("v%0d_rt_val", i), ex_rt_val, vecs[i].rtv);
                check($sformatf("v%0d_pc4", i), ex_pc4, pc4);
                if (vecs[i].op == 4'd5 || vecs[i].op == 4'd6)
                    check($sformatf("v%0d_shamt", i), {27'h0, ex_shamt}, {27'h0, vecs[i].sh});
            end
        end

        // Load-use: lw $4,0($10) then add $5,$4,$1 -> one stall cycle and a bubble.
        set_idle(); tick();
        drive(itype('h23, 10, 4, 16'h0), 32'h100);
        tick();
        drive(rtype(4, 1, 5, 0, 'h20), 32'h104);
        check("lu_stall", {31'h0, stall_out}, 32'h1);
        tick();
        check("lu_bubble", {31'h0, ex_valid}, 32'h0);
        check("lu_bubble_wr", {31'h0, ex_reg_write}, 32'h0);
        check("lu_stall_released", {31'h0, stall_out}, 32'h0);
        tick();
        check("lu_issue_valid", {31'h0, ex_valid}, 32'h1);
        check("lu_issue_rw", {27'h0, ex_rw}, 32'd5);
        check("lu_issue_rs_val", ex_rs_val, 32'd4);
        check("lu_issue_rs", {27'h0, ex_rs}, 32'd4);

        // lw into $0 never stalls.
        set_idle(); tick();
        drive(itype('h23, 10, 0, 16'h0), 32'h200);
        tick();
        check("lw0_mem_read", {31'h0, ex_mem_read}, 32'h1);
        drive(rtype(0, 1, 5, 0, 'h20), 32'h204);
        check("lw0_no_stall", {31'h0, stall_out}, 32'h0);
        tick();
        check("lw0_issue", {31'h0, ex_valid}, 32'h1);

        // Flush wins over a load-use hazard.
        set_idle(); tick();
        drive(itype('h23, 10, 4, 16'h0), 32'h300);
        tick();
        ex_flush = 1'b1;
        drive(rtype(4, 1, 5, 0, 'h20), 32'h304);
        check("fl_stall", {31'h0, stall_out}, 32'h0);
        tick();
        check("fl_bubble", {31'h0, ex_valid}, 32'h0);
        ex_flush = 1'b0;

        // mem_stall freezes ID/EX for three cycles, then the hazard reappears.
        set_idle(); tick();
        drive(itype('h23, 10, 4, 16'h0020), 32'h400);
        tick();
        mem_stall = 1'b1;
        drive(rtype(4, 1, 5, 0, 'h20), 32'h404);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("ms%0d_stall", c), {31'h0, stall_out}, 32'h0);
            tick();
            check($sformatf("ms%0d_valid", c), {31'h0, ex_valid}, 32'h1);
            check($sformatf("ms%0d_mem_read", c), {31'h0, ex_mem_read}, 32'h1);
            check($sformatf("ms%0d_rw", c), {27'h0, ex_rw}, 32'd4);
            check($sformatf("ms%0d_imm", c), ex_imm, 32'h20);
            check($sformatf("ms%0d_pc4", c), ex_pc4, 32'h400);
        end
        mem_stall = 1'b0;
        #1;
        check("ms_after_stall", {31'h0, stall_out}, 32'h1);

        // Jump target and suppression of jump_valid.
        set_idle(); tick();
        drive(32'h08040000, 32'h00400008);
        check("j_valid", {31'h0, jump_valid}, 32'h1);
        check("j_target", jump_target, 32'h00100000);
        ex_flush = 1'b1; #1;
        check("j_flush", {31'h0, jump_valid}, 32'h0);
        ex_flush = 1'b0; mem_stall = 1'b1; #1;
        check("j_mem_stall", {31'h0, jump_valid}, 32'h0);
        mem_stall = 1'b0;

        // Illegal pulse lasts exactly one cycle.
        set_idle(); tick();
        drive(itype('h3f, 1, 2, 16'h0), 32'h500);
        tick();
        check("ill_pulse", {31'h0, illegal_instr}, 32'h1);
        check("ill_bubble", {31'h0, ex_valid}, 32'h0);
        drive(32'h00221820, 32'h504);
        tick();
        check("ill_pulse_end", {31'h0, illegal_instr}, 32'h0);
        check("ill_next_issue", {31'h0, ex_valid}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID stage of the 32-bit MIPS-subset pipeline: decodes the IF/ID instruction and drives the register-file read addresses.
- Captures the read operands, control fields and immediate into the ID/EX pipeline register.
- Detects load-use hazards, stalling IF one cycle and inserting a bubble. Resolves J locally, redirecting IF.
- Forwarding into EX is owned by the EX stage, not this block.

Parameters:
- RESET_PC4, 32'h00000004, value of ex_pc4 after clear.

Ports:
- clock  in  1  pipeline clock; all state updates on posedge.
- clear  in  1  synchronous active-high reset.
- if_valid  in  1  IF/ID holds a real instruction.
- if_instr  in  32  instruction word.
- if_pc4  in  32  PC+4 of that instruction.
- mem_stall  in  1  freeze: hold all state.
- ex_flush  in  1  branch taken in EX; kill the ID instruction.
- RA / RB  out  5  register-file read addresses: rs / rt, combinational from if_instr.
- read_data1 / read_data2  in  32  register-file read data; register 0 reads as 0.
- stall_out  out  1  combinational: hold PC and IF/ID this cycle.
- jump_valid  out  1  combinational: J decoded; IF redirects and flushes IF/ID.
- jump_target  out  32  {if_pc4[31:28], if_instr[25:0], 2'b00}.
- illegal_instr  out  1  registered one-cycle pulse for an unknown opcode or funct.
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src  out  1 each  ID/EX control.
- ex_branch  out  2  00 none, 01 beq, 10 bne.
- ex_alu_op  out  4  from the package.
- ex_rs_val, ex_rt_val, ex_imm, ex_pc4  out  32  operands, immediate and PC+4.
- ex_rs, ex_rt, ex_rw, ex_shamt  out  5  register numbers for EX forwarding, destination, shift amount.

Behaviour:
- Decoded set:
  - R-type funct: add 20, sub 22, and 24, or 25, slt 2a, sll 00, srl 02.
  - I-type: addi 08, andi 0c, ori 0d, lui 0f, lw 23, sw 2b, beq 04, bne 05.
  - Jump: j 02.
- ex_rw: rd for R-type, rt for addi/andi/ori/lui/lw, 0 otherwise. ex_reg_write = 0 whenever ex_rw = 0.
- ex_imm:
  - sign-extended for addi/lw/sw/beq/bne;
  - zero-extended for andi/ori;
  - {imm,16'h0} for lui, which uses alu_op ADD with alu_src = 1 and rs = 0.
- Register uses:
  - rs and rt: R-type arithmetic, sw, beq, bne.
  - rt only: sll, srl.
  - rs only: addi, andi, ori, lw.
  - none: lui, j.
- Load-use hazard, hz:
  - Condition: if_valid & ex_valid & ex_mem_read & ex_rw≠0 & (used rs = ex_rw | used rt = ex_rw).
  - Effect: stall_out = 1 and ID/EX loads a bubble. Exactly 1 stall cycle, because the next cycle ex_mem_read is 0.
- Per-posedge priority:
  - clear: every ex_* output is 0 except ex_pc4 = RESET_PC4; illegal_instr = 0.
  - mem_stall: ID/EX holds, illegal_instr = 0. stall_out and jump_valid are forced to 0.
  - ex_flush: bubble. stall_out = 0 and jump_valid = 0, even if hz or J is present.
  - hz: bubble. stall_out = 1.
  - ~if_valid, illegal, or J: bubble. illegal_instr = 1 only when if_valid and the instruction is illegal.
  - Otherwise: load the decoded fields with ex_valid = 1.
- Bubble definition: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write and ex_branch are all 0. The data fields are don't-care but are still loaded.
- Same-cycle writeback: the register file writes on the negative clock edge, so a WB write is visible to the ID read in the same cycle. No WB-to-ID bypass is required.
- Latency: 1 cycle from IF/ID to ID/EX.

Decomposition:
- Package pipe_pkg holds:
  - opcode and funct constants;
  - ALU op encodings: ADD 0, SUB 1, AND 2, OR 3, SLT 4, SLL 5, SRL 6;
  - branch encodings.
- One sub-module, instr_decoder: purely combinational; maps the instruction to control fields, immediate, use_rs/use_rt and illegal. The hazard logic and ID/EX register live in decode_stage.

Test Plan:
- Clear asserted for 2 cycles → ex_valid = 0, ex_pc4 = 4, stall_out = 0. With if_instr = 0 and if_valid = 0 → all control outputs 0.
- add $3,$1,$2 (0x00221820) with register-file init $1 = 1, $2 = 2 → next cycle: ex_rs_val = 1, ex_rt_val = 2, ex_rw = 3, ex_alu_op = ADD, ex_reg_write = 1.
- lw $4,0($10) followed by add $5,$4,$1 → 1 cycle with stall_out = 1 and an ex_valid = 0 bubble, then the add issues. Repeating with lw writing $0 → no stall.
- lw $4 in EX, add using $4 in ID, ex_flush = 1 → stall_out = 0, bubble. Repeating with mem_stall = 1 for 3 cycles → ID/EX unchanged throughout.
- j 0x0040000 with if_pc4 = 0x00400008 → jump_valid = 1, jump_target = 0x00100000, next ex_valid = 0. Opcode 0x3f → illegal_instr pulse and a bubble.
- lui $7,0x1234 → ex_imm = 0x12340000, RA = 0, ex_alu_src = 1. ori $7,$7,0xFFFF → ex_imm = 0x0000FFFF, not sign-extended.
